// File: rtl/pipe_pkg.sv
// Shared constants and the ALU-control decode for the RV64 execute stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipe_pkg;

  // 4-bit ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // alu_op codes from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Operand-source selects produced by the forwarding unit
  localparam logic [1:0] FWD_ID  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // funct3 000 means SUB only for register-register forms; with an immediate
  // operand bit 30 belongs to the immediate, so it must decode as ADD.
  function automatic logic [3:0] alu_decode(input logic [1:0] alu_op,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5,
                                            input logic       alu_src);
    logic [3:0] ctrl;
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ctrl = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// Forwarding decision for the two EX operands (RAW hazards vs EX/MEM and MEM/WB).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: rs1/rs2 (EX sources), mem_reg_write/mem_rd (EX/MEM), wb_reg_write/wb_rd
//   (MEM/WB) in; forward_a/forward_b (FWD_* selects) out.
// Build option: FORWARD_EN enables forwarding; otherwise both selects are FWD_ID.
module ex_forward_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b
);

`ifdef FORWARD_EN
  // x0 is hardwired to zero, so a write to it is never a real producer.
  // EX/MEM is checked first: it holds the younger of the two results.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] rs);
    logic [1:0] sel;
    sel = FWD_ID;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  always_comb begin
    forward_a = pick(rs1);
    forward_b = pick(rs2);
  end
`else
  // Without forwarding the compiler/software must schedule around hazards.
  assign forward_a = FWD_ID;
  assign forward_b = FWD_ID;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs1, rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd};
`endif

endmodule

// File: rtl/execute_mem_pipe.sv
// RV64 execute stage (forwarded operands, ALU, branch target) plus the EX/MEM register.
// Latency: ALU/branch outputs combinational; *_d3 outputs one clk after the inputs.
// Backpressure: none; EX/MEM loads on every rising clk, no stall or enable.
// Ports: clk, rst (async, active-low); ID/EX data, addresses, immediate and control in;
//   MEM/WB write-back (wb_reg_write/wb_rd/wb_data) in; forward_a/b, alu_ctrl,
//   alu_result, alu_zero, pc_branch out; *_d3 registered EX/MEM copies out.
// Build option: FORWARD_EN (see ex_forward_unit).
module execute_mem_pipe
  import pipe_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   imm,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              branch,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [3:0]        alu_ctrl,
  output logic [XLEN-1:0]   alu_result,
  output logic              alu_zero,
  output logic [XLEN-1:0]   pc_branch,
  output logic              mem_to_reg_d3,
  output logic              reg_write_d3,
  output logic              branch_d3,
  output logic              mem_read_d3,
  output logic              mem_write_d3,
  output logic [XLEN-1:0]   pc_branch_d3,
  output logic [XLEN-1:0]   alu_result_d3,
  output logic              alu_zero_d3,
  output logic [XLEN-1:0]   rs2_data_d3,
  output logic [REG_AW-1:0] rd_d3
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] op_b;
  logic [5:0]      shamt;

  ex_forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs1          (rs1),
    .rs2          (rs2),
    .mem_reg_write(reg_write_d3),
    .mem_rd       (rd_d3),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .forward_a    (forward_a),
    .forward_b    (forward_b)
  );

  // Select 11 is never produced; it falls back to the ID/EX value.
  always_comb begin
    case (forward_a)
      FWD_MEM: src_a = alu_result_d3;
      FWD_WB:  src_a = wb_data;
      default: src_a = rs1_data;
    endcase
    case (forward_b)
      FWD_MEM: src_b = alu_result_d3;
      FWD_WB:  src_b = wb_data;
      default: src_b = rs2_data;
    endcase
  end

  // The immediate replaces operand B only; stores still need the forwarded rs2.
  assign op_b  = alu_src ? imm : src_b;
  assign shamt = op_b[5:0];

  assign alu_ctrl = alu_decode(alu_op, funct3, funct7b5, alu_src);

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_result = src_a + op_b;
      ALU_SUB:  alu_result = src_a - op_b;
      ALU_AND:  alu_result = src_a & op_b;
      ALU_OR:   alu_result = src_a | op_b;
      ALU_XOR:  alu_result = src_a ^ op_b;
      ALU_SLL:  alu_result = src_a << shamt;
      ALU_SRL:  alu_result = src_a >> shamt;
      ALU_SRA:  alu_result = $signed(src_a) >>> shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (src_a < op_b)};
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero  = (alu_result == '0);
  assign pc_branch = pc + imm;

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_to_reg_d3 <= 1'b0;
      reg_write_d3  <= 1'b0;
      branch_d3     <= 1'b0;
      mem_read_d3   <= 1'b0;
      mem_write_d3  <= 1'b0;
      pc_branch_d3  <= '0;
      alu_result_d3 <= '0;
      alu_zero_d3   <= 1'b0;
      rs2_data_d3   <= '0;
      rd_d3         <= '0;
    end else begin
      mem_to_reg_d3 <= mem_to_reg;
      reg_write_d3  <= reg_write;
      branch_d3     <= branch;
      mem_read_d3   <= mem_read;
      mem_write_d3  <= mem_write;
      pc_branch_d3  <= pc_branch;
      alu_result_d3 <= alu_result;
      alu_zero_d3   <= alu_zero;
      rs2_data_d3   <= src_b;
      rd_d3         <= rd;
    end
  end

endmodule

// File: tb/tb_execute_mem_pipe.sv
// Self-checking bench for execute_mem_pipe: directed steps, scoreboard queue for EX/MEM.
// Latency: expected EX/MEM records are pushed at drive time, popped one edge later.
// Backpressure: none.
module tb_execute_mem_pipe;

`ifdef FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc, rs1_data, rs2_data, imm, wb_data;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [1:0]  alu_op;
  logic        alu_src, funct7b5, branch, mem_read, mem_write, mem_to_reg, reg_write;
  logic        wb_reg_write;
  logic [2:0]  funct3;
  logic [1:0]  forward_a, forward_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result, pc_branch, pc_branch_d3, alu_result_d3, rs2_data_d3;
  logic        alu_zero, mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3;
  logic        mem_write_d3, alu_zero_d3;
  logic [4:0]  rd_d3;

  always #5 clk = ~clk;

  execute_mem_pipe dut (
    .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
    .funct3(funct3), .funct7b5(funct7b5), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .forward_a(forward_a), .forward_b(forward_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .pc_branch(pc_branch),
    .mem_to_reg_d3(mem_to_reg_d3), .reg_write_d3(reg_write_d3), .branch_d3(branch_d3),
    .mem_read_d3(mem_read_d3), .mem_write_d3(mem_write_d3), .pc_branch_d3(pc_branch_d3),
    .alu_result_d3(alu_result_d3), .alu_zero_d3(alu_zero_d3),
    .rs2_data_d3(rs2_data_d3), .rd_d3(rd_d3)
  );

  typedef struct {
    logic [63:0] alu_result;
    logic [63:0] pc_branch;
    logic [63:0] rs2_fwd;
    logic        zero;
    logic [4:0]  rd;
    logic        mem_to_reg, reg_write, branch, mem_read, mem_write;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Bench-side image of the EX/MEM register, taken from its own expectations.
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_alu;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
    if (!FWD_EN) return 2'b00;
    if (m_rw && m_rd != 5'd0 && m_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] exp_ctrl();
    if (alu_op == 2'b01) return 4'b0110;
    if (alu_op != 2'b10) return 4'b0010;
    unique case (funct3)
      3'b000: return (funct7b5 && !alu_src) ? 4'b0110 : 4'b0010;
      3'b001: return 4'b0100;
      3'b010: return 4'b1000;
      3'b011: return 4'b1001;
      3'b100: return 4'b0011;
      3'b101: return funct7b5 ? 4'b0111 : 4'b0101;
      3'b110: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [63:0] exp_alu(input logic [3:0] c, input logic [63:0] a,
                                          input logic [63:0] b);
    logic signed [63:0] sa, sb_v;
    sa = a;
    sb_v = b;
    case (c)
      4'b0010: return a + b;
      4'b0110: return a + (~b + 64'd1);
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0100: return a << b[5:0];
      4'b0101: return a >> b[5:0];
      4'b0111: return sa >>> b[5:0];
      4'b1000: return (sa < sb_v) ? 64'd1 : 64'd0;
      4'b1001: return (a < b) ? 64'd1 : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  task automatic idle();
    pc = 0; rs1_data = 0; rs2_data = 0; imm = 0; wb_data = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0; alu_op = 0; alu_src = 0; funct3 = 0;
    funct7b5 = 0; branch = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic chk_d3_zero(input string tag);
    chk({tag, ".alu_result_d3"}, alu_result_d3, 0);
    chk({tag, ".pc_branch_d3"}, pc_branch_d3, 0);
    chk({tag, ".rs2_data_d3"}, rs2_data_d3, 0);
    chk({tag, ".rd_d3"}, rd_d3, 0);
    chk({tag, ".ctrl_d3"}, {mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3,
                            mem_write_d3, alu_zero_d3}, 0);
  endtask

  // Called with inputs settled (#1 after the negedge drive). Checks the
  // combinational outputs, pushes the EX/MEM expectation, clocks once, pops.
  task automatic step(input string tag);
    logic [1:0]  fa, fb;
    logic [3:0]  c;
    logic [63:0] a, b, res;
    exp_t e, got;
    fa = exp_fwd(rs1);
    fb = exp_fwd(rs2);
    a = (fa == 2'b10) ? m_alu : (fa == 2'b01) ? wb_data : rs1_data;
    b = (fb == 2'b10) ? m_alu : (fb == 2'b01) ? wb_data : rs2_data;
    c = exp_ctrl();
    res = exp_alu(c, a, alu_src ? imm : b);
    chk({tag, ".forward_a"}, forward_a, fa);
    chk({tag, ".forward_b"}, forward_b, fb);
    chk({tag, ".alu_ctrl"}, alu_ctrl, c);
    chk({tag, ".alu_result"}, alu_result, res);
    chk({tag, ".alu_zero"}, alu_zero, res == 64'd0);
    chk({tag, ".pc_branch"}, pc_branch, pc + imm);
    e.alu_result = res; e.pc_branch = pc + imm; e.rs2_fwd = b; e.zero = (res == 64'd0);
    e.rd = rd; e.mem_to_reg = mem_to_reg; e.reg_write = reg_write; e.branch = branch;
    e.mem_read = mem_read; e.mem_write = mem_write;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk({tag, ".sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk({tag, ".alu_result_d3"}, alu_result_d3, got.alu_result);
      chk({tag, ".pc_branch_d3"}, pc_branch_d3, got.pc_branch);
      chk({tag, ".rs2_data_d3"}, rs2_data_d3, got.rs2_fwd);
      chk({tag, ".alu_zero_d3"}, alu_zero_d3, got.zero);
      chk({tag, ".rd_d3"}, rd_d3, got.rd);
      chk({tag, ".ctrl_d3"}, {mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3},
          {got.mem_to_reg, got.reg_write, got.branch, got.mem_read, got.mem_write});
      m_rw = got.reg_write; m_rd = got.rd; m_alu = got.alu_result;
    end
  endtask

  initial begin
    idle();
    m_rw = 0; m_rd = 0; m_alu = 0;
    rst = 1'b0;
    #2;
    chk_d3_zero("reset_init");
    #5;                          // t=7, after the first edge, away from any edge
    rst = 1'b1;

    // R-type sub 10 - 3
    @(negedge clk); idle();
    alu_op = 2'b10; funct3 = 3'b000; funct7b5 = 1; rs1 = 1; rs2 = 2;
    rs1_data = 10; rs2_data = 3; rd = 7; reg_write = 1;
    #1;
    chk("rsub.alu_ctrl_fixed", alu_ctrl, 4'b0110);
    chk("rsub.result_fixed", alu_result, 7);
    chk("rsub.zero_fixed", alu_zero, 0);
    step("rsub");

    // producer: x5 = 40 + 2
    @(negedge clk); idle();
    rs1 = 1; rs2 = 2; rs1_data = 40; rs2_data = 2; rd = 5; reg_write = 1;
    #1; step("prod_x5");

    // consumer of x5 with stale 0
    @(negedge clk); idle();
    rs1 = 5; rs1_data = 0; rs2_data = 1; rd = 8;
    #1;
    chk("exmem_fwd.forward_a_fixed", forward_a, FWD_EN ? 2'b10 : 2'b00);
    chk("exmem_fwd.result_fixed", alu_result, FWD_EN ? 64'd43 : 64'd1);
    step("exmem_fwd");

    // producer: x6 = 1
    @(negedge clk); idle();
    rs1_data = 1; rd = 6; reg_write = 1;
    #1; step("prod_x6");

    // priority: EX/MEM x6=1 vs MEM/WB x6=2; this one writes x0 with reg_write=1
    @(negedge clk); idle();
    alu_op = 2'b01; rs2 = 6; rs1_data = 100; rs2_data = 50;
    wb_reg_write = 1; wb_rd = 6; wb_data = 2; rd = 0; reg_write = 1;
    #1;
    chk("prio.forward_b_fixed", forward_b, FWD_EN ? 2'b10 : 2'b00);
    chk("prio.result_fixed", alu_result, FWD_EN ? 64'd99 : 64'd50);
    step("prio");
    chk("rd0.reg_write_d3_kept", reg_write_d3, 1);

    // both sources target x0 -> never forwarded
    @(negedge clk); idle();
    wb_reg_write = 1; wb_rd = 0; wb_data = 64'h77; rs2_data = 5; rs1_data = 3; rd = 10;
    #1;
    chk("rd0.forward_b_fixed", forward_b, 2'b00);
    chk("rd0.forward_a_fixed", forward_a, 2'b00);
    step("rd0");

    // MEM/WB-only forward on rs1
    @(negedge clk); idle();
    wb_reg_write = 1; wb_rd = 9; wb_data = 64'h55; rs1 = 9; rs2_data = 1;
    #1;
    chk("wb_fwd.forward_a_fixed", forward_a, FWD_EN ? 2'b01 : 2'b00);
    chk("wb_fwd.result_fixed", alu_result, FWD_EN ? 64'h56 : 64'h1);
    step("wb_fwd");

    // branch: 9 - 9, pc 0x100, imm -8
    @(negedge clk); idle();
    alu_op = 2'b01; rs1 = 11; rs2 = 12; rs1_data = 9; rs2_data = 9;
    pc = 64'h100; imm = -64'sd8; branch = 1;
    #1;
    chk("branch.zero_fixed", alu_zero, 1);
    chk("branch.pc_branch_fixed", pc_branch, 64'hF8);
    step("branch");
    chk("branch.branch_d3_fixed", branch_d3, 1);

    // store: base 0x1000 + 16, store data forwarded from MEM/WB
    @(negedge clk); idle();
    alu_src = 1; imm = 16; rs1 = 14; rs1_data = 64'h1000; rs2 = 13; rs2_data = 0;
    wb_reg_write = 1; wb_rd = 13; wb_data = 64'hDEAD; mem_write = 1;
    #1; step("store");
    chk("store.alu_result_d3_fixed", alu_result_d3, 64'h1010);
    chk("store.rs2_data_d3_fixed", rs2_data_d3, FWD_EN ? 64'hDEAD : 64'h0);
    chk("store.mem_write_d3_fixed", mem_write_d3, 1);

    // funct3 sweep with signed/unsigned edge operands
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); idle();
      alu_op = 2'b10; funct3 = 3'(i % 8); funct7b5 = (i >= 8) || (i == 5);
      alu_src = (i == 8); imm = 64'd5;
      rs1_data = 64'h8000_0000_0000_00F0; rs2_data = 64'd4 + 64'(i);
      rd = 5'(i + 1); mem_read = i[0]; mem_to_reg = i[1];
      #1; step($sformatf("f3_%0d", i));
    end

    // alu_op 11 decodes as ADD
    @(negedge clk); idle();
    alu_op = 2'b11; funct3 = 3'b100; rs1_data = 64'hFFFF_FFFF_FFFF_FFFF; rs2_data = 2;
    #1;
    chk("aluop11.alu_ctrl_fixed", alu_ctrl, 4'b0010);
    chk("aluop11.wrap_fixed", alu_result, 64'h1);
    step("aluop11");

    // randomized back-to-back traffic exercising the forwarding paths
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pc = {$urandom, $urandom}; imm = {$urandom, $urandom};
      rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
      wb_data = {$urandom, $urandom};
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      alu_op = 2'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
      alu_src = 1'($urandom); branch = 1'($urandom); mem_read = 1'($urandom);
      mem_write = 1'($urandom); mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom);
      #1; step($sformatf("rand_%0d", i));
    end

    // mid-run asynchronous reset, checked between edges
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_d3_zero("reset_mid");
    @(posedge clk);
    #1;
    chk_d3_zero("reset_held");
    m_rw = 0; m_rd = 0; m_alu = 0;

    // release, then the next edge captures
    @(negedge clk);
    rst = 1'b1;
    idle();
    rs1_data = 64'h20; rs2_data = 64'h3; rd = 4; reg_write = 1; mem_read = 1;
    #1; step("post_reset");
    chk("post_reset.alu_result_d3_fixed", alu_result_d3, 64'h23);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
